sb_pll40_core_model: RTL and testbench

SB_PLL40_CORE_MODEL -- requirements
Module: sb_pll40_core_model

---
 rtl/sb_pll40_core_model.sv | 139 +++++++++++++
 tb/tb_sb_pll40_core_model.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sb_pll40_core_model.sv
// Behavioural iCE40 PLL40 core model: measures REFERENCECLK periods, validates the
// divider setup and synthesizes a 50% duty output clock using real-valued timing.
`timescale 1ns / 1ps

module sb_pll40_core_model #(
    parameter string      FEEDBACK_PATH = "SIMPLE",
    parameter string      PLLOUT_SELECT = "GENCLK",
    parameter logic [3:0] DIVR          = 4'b0000,
    parameter logic [6:0] DIVF          = 7'b0000000,
    parameter logic [2:0] DIVQ          = 3'b001,
    parameter logic [2:0] FILTER_RANGE  = 3'b001
) (
    input  logic REFERENCECLK,
    input  logic RESETB,
    input  logic BYPASS,
    output logic PLLOUTCORE,
    output logic PLLOUTGLOBAL,
    output logic LOCK
);
    localparam int  LOCK_PERIODS = 16;
    localparam real DIV_IN       = real'(DIVR) + 1.0;
    localparam real DIV_FB       = real'(DIVF) + 1.0;
    localparam real DIV_OUT      = real'(32'd1 << DIVQ);
    localparam real RANGE_EPS    = 1.0e-6;

    realtime last_edge_t = 0.0;
    realtime prev_period = 0.0;
    realtime half_period = 1.0;
    realtime now_t       = 0.0;
    realtime period      = 0.0;
    realtime tout        = 0.0;
    bit      have_edge    = 1'b0;
    bit      have_period  = 1'b0;
    bit      lock_int     = 1'b0;
    bit      gen_clk      = 1'b0;
    bit      err_reported = 1'b0;
    bit      cfg_ok       = 1'b0;
    int      good_cnt     = 0;
    int      edge_id      = 0;
    int      run_id       = 0;

    // Bumping run_id orphans any output generator still sleeping on a half period.
    task automatic drop_lock();
        lock_int = 1'b0;
        gen_clk  = 1'b0;
        run_id++;
    endtask

    task automatic restart_count();
        good_cnt     = 0;
        err_reported = 1'b0;
    endtask

    task automatic run_output(input int id);
        while (run_id == id) begin
            #(half_period);
            if (run_id == id) gen_clk = ~gen_clk;
        end
    endtask

    task automatic watchdog(input int id, input realtime limit);
        #(limit);
        if (edge_id == id && RESETB) begin
            drop_lock();
            restart_count();
            have_edge   = 1'b0;
            have_period = 1'b0;
        end
    endtask

    task automatic evaluate(input realtime tref, output bit ok, output realtime t_out);
        real fpfd;
        real fvco;
        bit  simple;
        simple = (FEEDBACK_PATH == "SIMPLE");
        fpfd   = 1000.0 / (tref * DIV_IN);
        fvco   = simple ? fpfd * DIV_FB : fpfd * DIV_FB * DIV_OUT;
        t_out  = simple ? tref * DIV_IN * DIV_OUT / DIV_FB : tref * DIV_IN / DIV_FB;
        ok = (fpfd >= 10.0 * (1.0 - RANGE_EPS)) && (fpfd <= 133.0 * (1.0 + RANGE_EPS)) &&
             (fvco >= 533.0 * (1.0 - RANGE_EPS)) && (fvco <= 1066.0 * (1.0 + RANGE_EPS)) &&
             !(simple && DIVQ == 3'd0);
        if (PLLOUT_SELECT == "GENCLK_HALF") t_out = 2.0 * t_out;
        else if (PLLOUT_SELECT != "GENCLK") ok = 1'b0;
    endtask

    // Measurement, lock qualification and output launch all live in this one process.
    always begin
        @(posedge REFERENCECLK or negedge RESETB);
        if (!RESETB) begin
            drop_lock();
            restart_count();
            have_edge   = 1'b0;
            have_period = 1'b0;
            edge_id++;
            wait (RESETB);
        end else begin
            now_t = $realtime;
            edge_id++;
            if (have_edge) begin
                period = now_t - last_edge_t;
                if (have_period && (period > prev_period * 1.01 || period < prev_period * 0.99)) begin
                    drop_lock();
                    restart_count();
                end
                good_cnt    = (good_cnt < LOCK_PERIODS) ? good_cnt + 1 : LOCK_PERIODS;
                prev_period = period;
                have_period = 1'b1;
                evaluate(period, cfg_ok, tout);
                half_period = tout / 2.0;
                if (good_cnt == LOCK_PERIODS && !lock_int) begin
                    if (cfg_ok) begin
                        lock_int = 1'b1;
                        gen_clk  = 1'b1;
                        run_id++;
                        fork
                            run_output(run_id);
                        join_none
                    end else if (!err_reported) begin
                        err_reported = 1'b1;
                        $display("sb_pll40_core_model %m: error, invalid configuration (Tref=%0.3f ns, DIVR=%0d DIVF=%0d DIVQ=%0d FILTER_RANGE=%0d)",
                                 period, DIVR, DIVF, DIVQ, FILTER_RANGE);
                    end
                end
            end
            have_edge   = 1'b1;
            last_edge_t = now_t;
            if (have_period) begin
                fork
                    watchdog(edge_id, 4.0 * prev_period);
                join_none
            end
        end
    end

    assign LOCK         = lock_int & ~BYPASS & RESETB;
    assign PLLOUTCORE   = BYPASS ? REFERENCECLK : (gen_clk & RESETB);
    assign PLLOUTGLOBAL = PLLOUTCORE;

endmodule

// File: tb/tb_sb_pll40_core_model.sv
// Directed bench for sb_pll40_core_model: lock timing, output period/duty,
// half-rate tap, bypass with an invalid VCO, reset pulse, clock stop and frequency step.
`timescale 1ns / 1ps

module tb_sb_pll40_core_model;
    logic ref_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic byp_a   = 1'b0;
    logic byp_e   = 1'b1;
    logic core_a, glob_a, lock_a;
    logic core_h, glob_h, lock_h;
    logic core_e, glob_e, lock_e;

    realtime ref_hi = 41.667;
    realtime ref_lo = 41.666;
    realtime cur_hi, cur_lo;
    bit      ref_run = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    realtime ref_t = 0.0, lock_t = 0.0, t_last = 0.0;
    realtime a_rise = 0.0, a_fall = 0.0, a_period = 0.0, a_high = 0.0, g_rise = 0.0;
    realtime h_rise = 0.0, h_period = 0.0;
    int      a_rises = 0;
    int      rises_before;

    sb_pll40_core_model #(.FEEDBACK_PATH("SIMPLE"), .PLLOUT_SELECT("GENCLK"),
                          .DIVR(4'd0), .DIVF(7'd83), .DIVQ(3'd5), .FILTER_RANGE(3'd1)) dut_a (
        .REFERENCECLK(ref_clk), .RESETB(rst_n), .BYPASS(byp_a),
        .PLLOUTCORE(core_a), .PLLOUTGLOBAL(glob_a), .LOCK(lock_a));

    sb_pll40_core_model #(.FEEDBACK_PATH("SIMPLE"), .PLLOUT_SELECT("GENCLK_HALF"),
                          .DIVR(4'd0), .DIVF(7'd83), .DIVQ(3'd5), .FILTER_RANGE(3'd1)) dut_h (
        .REFERENCECLK(ref_clk), .RESETB(rst_n), .BYPASS(1'b0),
        .PLLOUTCORE(core_h), .PLLOUTGLOBAL(glob_h), .LOCK(lock_h));

    sb_pll40_core_model #(.FEEDBACK_PATH("SIMPLE"), .PLLOUT_SELECT("GENCLK"),
                          .DIVR(4'd0), .DIVF(7'd127), .DIVQ(3'd5), .FILTER_RANGE(3'd1)) dut_e (
        .REFERENCECLK(ref_clk), .RESETB(rst_n), .BYPASS(byp_e),
        .PLLOUTCORE(core_e), .PLLOUTGLOBAL(glob_e), .LOCK(lock_e));

    // Each reference cycle latches its high/low times just before its rising edge.
    always begin
        if (ref_run) begin
            cur_hi  = ref_hi;
            cur_lo  = ref_lo;
            ref_clk = 1'b1;
            #(cur_hi);
            ref_clk = 1'b0;
            #(cur_lo);
        end else begin
            #1;
        end
    end

    always @(posedge ref_clk) ref_t = $realtime;
    always @(posedge lock_a)  lock_t = $realtime;
    always @(negedge core_a)  a_fall = $realtime;
    always @(posedge glob_a)  g_rise = $realtime;

    always @(posedge core_a) begin
        a_period = $realtime - a_rise;
        a_high   = a_fall - a_rise;
        a_rise   = $realtime;
        a_rises++;
    end

    always @(posedge core_h) begin
        h_period = $realtime - h_rise;
        h_rise   = $realtime;
    end

    function automatic longint to_ps(input realtime t);
        return longint'(t * 1000.0);
    endfunction

    task automatic check_output(input string tag, input longint observed,
                                input longint expected, input longint tol);
        longint diff;
        compared++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, required %0d (tol %0d) at %0t",
                     tag, observed, expected, tol, $time);
        end
    endtask

    // LOCK must stay low through edge n-1 and rise, with the first output edge, on edge n.
    task automatic expect_lock(input int n, input string tag);
        repeat (n - 1) @(posedge ref_clk);
        #1;
        check_output({tag, "_lock_pre"}, 64'(lock_a), 0, 0);
        check_output({tag, "_out_pre"}, 64'(core_a), 0, 0);
        @(posedge ref_clk);
        #1;
        check_output({tag, "_lock"}, 64'(lock_a), 1, 0);
        check_output({tag, "_lock_time"}, to_ps(lock_t), to_ps(ref_t), 0);
        check_output({tag, "_first_rise"}, to_ps(a_rise), to_ps(ref_t), 0);
    endtask

    task automatic wait_core_high(input string tag);
        for (int i = 0; i < 400 && !core_a; i++) #0.1;
        check_output(tag, 64'(core_a), 1, 0);
    endtask

    initial begin
        $display("[TB] start");

        #20;
        check_output("rst_lock", 64'(lock_a), 0, 0);
        check_output("rst_out", 64'(core_a), 0, 0);
        check_output("rst_byp_out", 64'(core_e), 1, 0);

        @(negedge ref_clk);
        #10;
        rst_n = 1'b1;
        expect_lock(17, "init");
        check_output("half_lock", 64'(lock_h), 1, 0);

        #800;
        check_output("period_12m", to_ps(a_period), longint'(83333.0 * 32.0 / 84.0), 2);
        check_output("high_12m", to_ps(a_high), longint'(83333.0 * 16.0 / 84.0), 2);
        check_output("period_half", to_ps(h_period), longint'(83333.0 * 64.0 / 84.0), 2);
        check_output("global_rise", to_ps(g_rise), to_ps(a_rise), 0);
        check_output("global_level", 64'(glob_a), 64'(core_a), 0);

        check_output("byp_lock", 64'(lock_e), 0, 0);
        @(posedge ref_clk);
        #5;
        check_output("byp_follow_hi", 64'(core_e), 1, 0);
        @(negedge ref_clk);
        #5;
        check_output("byp_follow_lo", 64'(core_e), 0, 0);
        byp_e = 1'b0;
        #1;
        check_output("unbyp_out", 64'(core_e), 0, 0);
        repeat (3) @(posedge ref_clk);
        #1;
        check_output("badvco_lock", 64'(lock_e), 0, 0);
        check_output("badvco_out", 64'(core_e), 0, 0);

        wait_core_high("rstp_core_high");
        #3;
        rst_n        = 1'b0;
        rises_before = a_rises;
        #0.001;
        check_output("rstp_lock", 64'(lock_a), 0, 0);
        check_output("rstp_out", 64'(core_a), 0, 0);
        #99.999;
        check_output("rstp_no_edge", 64'(a_rises), 64'(rises_before), 0);
        rst_n = 1'b1;
        expect_lock(17, "rstp");

        #500;
        @(posedge ref_clk);
        t_last  = $realtime;
        ref_run = 1'b0;
        #332.0;
        check_output("stop_lock_held", 64'(lock_a), 1, 0);
        #2.0;
        check_output("stop_lock_drop", 64'(lock_a), 0, 0);
        check_output("stop_out", 64'(core_a), 0, 0);
        ref_run = 1'b1;
        expect_lock(17, "restart");

        #500;
        @(posedge ref_clk);
        ref_hi = 50.0;
        ref_lo = 50.0;
        @(posedge ref_clk);
        #1;
        check_output("pre_step_lock", 64'(lock_a), 1, 0);
        @(posedge ref_clk);
        #1;
        check_output("step_lock_drop", 64'(lock_a), 0, 0);
        check_output("step_out", 64'(core_a), 0, 0);
        expect_lock(15, "step");
        #1000;
        check_output("period_10m", to_ps(a_period), longint'(100000.0 * 32.0 / 84.0), 2);
        check_output("high_10m", to_ps(a_high), longint'(100000.0 * 16.0 / 84.0), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
